// File: rtl/alu_seq.sv
// Registered ALU for the multi-cycle CPU's EX stage. Single-cycle ops complete in one cycle.
// MUL (shift-add) and DIV (restoring) iterate for WIDTH cycles behind a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             div0,
    output logic             bcond
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_ORR   = 4'd3;
    localparam logic [3:0] OP_NOT   = 4'd4;
    localparam logic [3:0] OP_TCP   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_LHI   = 4'd8;
    localparam logic [3:0] OP_PASSA = 4'd9;
    localparam logic [3:0] OP_BNE   = 4'd10;
    localparam logic [3:0] OP_BEQ   = 4'd11;
    localparam logic [3:0] OP_BGZ   = 4'd12;
    localparam logic [3:0] OP_BLZ   = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_DIV   = 4'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic [CW-1:0]    cnt_reg;

    // Single-cycle datapath, evaluated straight from the request inputs.
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_div0;
    logic             sc_bcond;
    logic             is_long;

    assign sum     = a + b;
    assign diff    = a - b;
    assign is_long = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        sc_ovf    = 1'b0;
        sc_div0   = 1'b0;
        sc_bcond  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   sc_result = a & b;
            OP_ORR:   sc_result = a | b;
            OP_NOT:   sc_result = ~a;
            OP_TCP:   sc_result = ~a + 1'b1;
            OP_SHL:   sc_result = {a[WIDTH-2:0], 1'b0};
            OP_SHR:   sc_result = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_LHI:   sc_result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_PASSA: sc_result = a;
            OP_BNE:   sc_bcond  = (a != b);
            OP_BEQ:   sc_bcond  = (a == b);
            OP_BGZ:   sc_bcond  = !a[WIDTH-1] && (a != '0);
            OP_BLZ:   sc_bcond  = a[WIDTH-1];
            OP_DIV: begin
                // Only reached on the single-cycle path when b is zero.
                sc_result = '1;
                sc_hi     = a;
                sc_div0   = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration step: acc_lo holds the multiplier (MUL) or the dividend/quotient (DIV).
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, a_reg} : '0);
    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    assign div_trial = div_shift - {1'b0, b_reg};

    always_comb begin
        if (op_reg == OP_DIV) begin
            step_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_reg[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    assign in_ready = (state_reg != RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            cnt_reg    <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            result_hi  <= '0;
            zero       <= 1'b1;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            div0       <= 1'b0;
            bcond      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (in_valid) begin
                        op_reg <= op;
                        a_reg  <= a;
                        b_reg  <= b;
                        if (is_long) begin
                            state_reg  <= RUN;
                            cnt_reg    <= CW'(WIDTH);
                            acc_hi_reg <= '0;
                            acc_lo_reg <= (op == OP_MUL) ? b : a;
                        end else begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                            result    <= sc_result;
                            result_hi <= sc_hi;
                            zero      <= (sc_result == '0);
                            neg       <= sc_result[WIDTH-1];
                            ovf       <= sc_ovf;
                            div0      <= sc_div0;
                            bcond     <= sc_bcond;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_reg <= step_hi;
                    acc_lo_reg <= step_lo;
                    cnt_reg    <= cnt_reg - 1'b1;
                    // Last step: publish the step result directly rather than waiting a cycle.
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        result    <= step_lo;
                        result_hi <= step_hi;
                        zero      <= (step_lo == '0);
                        neg       <= step_lo[WIDTH-1];
                        ovf       <= 1'b0;
                        div0      <= 1'b0;
                        bcond     <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=16: single-cycle ops, MUL/DIV latency,
// handshake stalls, back-to-back throughput and asynchronous reset mid-operation.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic        zero, neg, ovf, div0, bcond;

    int vectors = 0;
    int miscompares = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .div0      (div0),
        .bcond     (bcond)
    );

    always #5 clk = ~clk;

    // Single-cycle vectors: op, a, b, expected result, expected {zero,neg,ovf}.
    localparam logic [3:0]  S_OP [12] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4,
                                          4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    localparam logic [15:0] S_A  [12] = '{16'h7FFF, 16'h8000, 16'h0005, 16'hF0F0, 16'hF0F0, 16'h00FF,
                                          16'h0001, 16'h8001, 16'h8004, 16'hFFFF, 16'h0000, 16'hFFFF};
    localparam logic [15:0] S_B  [12] = '{16'h0001, 16'h0001, 16'h0003, 16'h3C3C, 16'h0F00, 16'h1111,
                                          16'h2222, 16'h3333, 16'h4444, 16'h12AB, 16'h5555, 16'h0001};
    localparam logic [15:0] S_R  [12] = '{16'h8000, 16'h7FFF, 16'h0002, 16'h3030, 16'hFFF0, 16'hFF00,
                                          16'hFFFF, 16'h0002, 16'hC002, 16'hAB00, 16'h0000, 16'h0000};
    localparam logic [2:0]  S_F  [12] = '{3'b011, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010,
                                          3'b010, 3'b000, 3'b010, 3'b010, 3'b100, 3'b100};

    // Branch vectors: op, a, b, expected bcond.
    localparam logic [3:0]  B_OP [7] = '{4'd13, 4'd12, 4'd11, 4'd10, 4'd12, 4'd13, 4'd10};
    localparam logic [15:0] B_A  [7] = '{16'h8000, 16'h0000, 16'h00AA, 16'h00AA, 16'h0001, 16'h7FFF, 16'h0001};
    localparam logic [15:0] B_B  [7] = '{16'h0000, 16'h0000, 16'h00AA, 16'h00AA, 16'h0000, 16'h0000, 16'h0002};
    localparam logic        B_C  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Drive one request at a negedge, return at the negedge of cycle 1 with in_valid dropped.
    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issue a MUL/DIV and return at the negedge of cycle 17.
    task automatic issue_long(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        issue(o, x, y);
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        in_valid = 1'b0;
        op = 4'd0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, zero, neg, ovf, div0, bcond} !== 7'b1010000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 1010000",
                     {in_ready, out_valid, zero, neg, ovf, div0, bcond});
        end
        vectors++;
        if ({result, result_hi} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 00000000", {result, result_hi});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        for (int i = 0; i < 12; i++) begin
            issue(S_OP[i], S_A[i], S_B[i]);
            vectors++;
            if (out_valid !== 1'b1 || result !== S_R[i] || result_hi !== 16'h0) begin
                miscompares++;
                $display("FAIL single_%0d: got v=%b r=%h hi=%h want v=1 r=%h hi=0000",
                         i, out_valid, result, result_hi, S_R[i]);
            end
            vectors++;
            if ({zero, neg, ovf, div0, bcond} !== {S_F[i], 2'b00}) begin
                miscompares++;
                $display("FAIL single_flags_%0d: got %b want %b",
                         i, {zero, neg, ovf, div0, bcond}, {S_F[i], 2'b00});
            end
            $display("single op=%0d a=%h b=%h -> r=%h z=%b n=%b o=%b", S_OP[i], S_A[i], S_B[i],
                     result, zero, neg, ovf);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pulse: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 7; i++) begin
            issue(B_OP[i], B_A[i], B_B[i]);
            vectors++;
            if (out_valid !== 1'b1 || bcond !== B_C[i] || result !== 16'h0 || zero !== 1'b1) begin
                miscompares++;
                $display("FAIL branch_%0d: got v=%b c=%b r=%h z=%b want v=1 c=%b r=0000 z=1",
                         i, out_valid, bcond, result, zero, B_C[i]);
            end
            $display("branch op=%0d a=%h b=%h -> bcond=%b", B_OP[i], B_A[i], B_B[i], bcond);
        end
    endtask

    task automatic test_mul;
        issue(4'd14, 16'h1234, 16'h5678);
        for (int k = 1; k <= 16; k++) begin
            if (k == 2) begin
                a = 16'hFFFF;
                b = 16'hFFFF;
            end
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_run_c%0d: got rdy=%b v=%b want rdy=0 v=0", k, in_ready, out_valid);
            end
            if (k == 8) begin
                vectors++;
                if (result !== 16'h0 || zero !== 1'b1) begin
                    miscompares++;
                    $display("FAIL mul_hold: got r=%h z=%b want r=0000 z=1", result, zero);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== 16'h0060 ||
            result_hi !== 16'h0626 || zero !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_done: got v=%b rdy=%b hi=%h r=%h z=%b o=%b want v=1 rdy=1 hi=0626 r=0060 z=0 o=0",
                     out_valid, in_ready, result_hi, result, zero, ovf);
        end
        $display("mul 1234*5678 -> %h_%h", result_hi, result);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_pulse: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_div;
        issue_long(4'd15, 16'd100, 16'd7);
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'd14 || result_hi !== 16'd2 || div0 !== 1'b0) begin
            miscompares++;
            $display("FAIL div_100_7: got v=%b q=%0d r=%0d d0=%b want v=1 q=14 r=2 d0=0",
                     out_valid, result, result_hi, div0);
        end
        $display("div 100/7 -> q=%0d r=%0d", result, result_hi);
        issue_long(4'd15, 16'hFFFF, 16'h0010);
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'h0FFF || result_hi !== 16'h000F) begin
            miscompares++;
            $display("FAIL div_ffff_10: got v=%b q=%h r=%h want v=1 q=0FFF r=000F",
                     out_valid, result, result_hi);
        end
        $display("div FFFF/0010 -> q=%h r=%h", result, result_hi);
        issue(4'd15, 16'h1234, 16'h0000);
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'hFFFF || result_hi !== 16'h1234 ||
            div0 !== 1'b1 || neg !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL div0: got v=%b q=%h r=%h d0=%b n=%b rdy=%b want v=1 q=FFFF r=1234 d0=1 n=1 rdy=1",
                     out_valid, result, result_hi, div0, neg, in_ready);
        end
        $display("div 1234/0 -> q=%h r=%h div0=%b", result, result_hi, div0);
    endtask

    task automatic test_run_request;
        issue(4'd14, 16'h1234, 16'h5678);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd1;
        a = 16'd5;
        b = 16'd3;
        for (int k = 3; k <= 16; k++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_c%0d: got rdy=%b v=%b want rdy=0 v=0", k, in_ready, out_valid);
            end
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== 16'h0060 || result_hi !== 16'h0626) begin
            miscompares++;
            $display("FAIL stall_mul_done: got v=%b rdy=%b r=%h hi=%h want v=1 rdy=1 r=0060 hi=0626",
                     out_valid, in_ready, result, result_hi);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'h0002 || result_hi !== 16'h0) begin
            miscompares++;
            $display("FAIL stall_sub_done: got v=%b r=%h hi=%h want v=1 r=0002 hi=0000",
                     out_valid, result, result_hi);
        end
        $display("queued sub 5-3 after mul -> r=%h", result);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_pulse: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  bo [4] = '{4'd0, 4'd1, 4'd3, 4'd5};
        logic [15:0] ba [4] = '{16'h0001, 16'h0010, 16'h0100, 16'h0002};
        logic [15:0] bb [4] = '{16'h0002, 16'h0001, 16'h0001, 16'h0000};
        logic [15:0] br [4] = '{16'h0003, 16'h000F, 16'h0101, 16'hFFFE};
        in_valid = 1'b1;
        op = bo[0];
        a = ba[0];
        b = bb[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                op = bo[i+1];
                a = ba[i+1];
                b = bb[i+1];
            end else begin
                in_valid = 1'b0;
            end
            vectors++;
            if (out_valid !== 1'b1 || result !== br[i]) begin
                miscompares++;
                $display("FAIL b2b_%0d: got v=%b r=%h want v=1 r=%h", i, out_valid, result, br[i]);
            end
            $display("b2b %0d -> r=%h", i, result);
        end
        // Two MULs with in_valid held: second operands are presented while the first runs.
        in_valid = 1'b1;
        op = 4'd14;
        a = 16'd3;
        b = 16'd5;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        repeat (16) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'h000F || result_hi !== 16'h0) begin
            miscompares++;
            $display("FAIL b2b_mul0: got v=%b hi=%h r=%h want v=1 hi=0000 r=000F", out_valid, result_hi, result);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_mul1_run: got rdy=%b v=%b want rdy=0 v=0", in_ready, out_valid);
        end
        repeat (16) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'h0001 || result_hi !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL b2b_mul1: got v=%b hi=%h r=%h want v=1 hi=FFFE r=0001", out_valid, result_hi, result);
        end
        $display("b2b mul FFFF*FFFF -> %h_%h", result_hi, result);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic seen;
        issue(4'd14, 16'h1234, 16'h5678);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, zero, neg, ovf, div0, bcond} !== 7'b1010000 ||
            {result, result_hi} !== 32'h0) begin
            miscompares++;
            $display("FAIL midrun_reset: got flags=%b r=%h hi=%h want flags=1010000 r=0000 hi=0000",
                     {in_ready, out_valid, zero, neg, ovf, div0, bcond}, result, result_hi);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_abort: got seen_valid=%b rdy=%b want seen_valid=0 rdy=1", seen, in_ready);
        end
        issue(4'd0, 16'h0002, 16'h0002);
        vectors++;
        if (out_valid !== 1'b1 || result !== 16'h0004) begin
            miscompares++;
            $display("FAIL post_reset_add: got v=%b r=%h want v=1 r=0004", out_valid, result);
        end
        $display("reset mid-run then add 2+2 -> r=%h", result);
    endtask

    initial begin
        test_reset();
        test_single();
        test_branch();
        test_mul();
        test_div();
        test_run_request();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU's combinational ALU. It adds iterative unsigned multiply and divide, a valid/ready handshake, and status flags. It sits in the multi-cycle CPU's EX stage: the control FSM issues one operation and waits for `out_valid`. Single-cycle ops complete in 1 cycle; MUL and DIV take WIDTH+1 cycles.

## Interface
Parameters:
- `WIDTH`, default 16: datapath width. Must be even and ≥ 4.

Ports:
- `clk`, input, 1: clock. One clock domain; all state updates on the rising edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: operation request.
- `in_ready`, output, 1: high when a request can be accepted.
- `op`, input, 4: operation code (see Operation).
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `out_valid`, output, 1: one-cycle completion pulse.
- `result`, output, WIDTH: primary result. For MUL, the low half of the product; for DIV, the quotient.
- `result_hi`, output, WIDTH: MUL high half, or DIV remainder. 0 for all other ops.
- `zero`, output, 1: `result` == 0.
- `neg`, output, 1: `result[WIDTH-1]`.
- `ovf`, output, 1: signed overflow, for ADD and SUB only; 0 otherwise.
- `div0`, output, 1: the completed DIV had `b` == 0.
- `bcond`, output, 1: branch condition, for branch ops only; 0 otherwise.

## Operation
Op codes:
- 0 ADD: a+b.
- 1 SUB: a−b.
- 2 AND: a&b.
- 3 ORR: a|b.
- 4 NOT: ~a.
- 5 TCP: ~a+1.
- 6 SHL: {a[W-2:0],0}.
- 7 SHR: arithmetic, {a[W-1],a[W-1:1]}.
- 8 LHI: {b[W/2-1:0], W/2 zeros}.
- 9 PASSA: a.
- 10 BNE: bcond = (a≠b).
- 11 BEQ: bcond = (a==b).
- 12 BGZ: bcond = signed a>0.
- 13 BLZ: bcond = signed a<0.
- 14 MUL: unsigned a×b, full 2W-bit product.
- 15 DIV: unsigned a÷b, giving quotient and remainder.

Rules:
- Branch ops (10–13) set `result` = 0.
- Arithmetic is modulo 2^WIDTH unless stated otherwise.
- ADD/SUB `ovf` is set when both operand signs agree (for SUB, a's sign and ~b's sign) and the result sign differs from them.
- Operands and op are captured into internal registers on accept. Input changes after accept have no effect.

FSM states:
- IDLE to DONE: on accept of ops 0–13, or of DIV with b==0. The result is computed combinationally from the inputs and registered on the accept edge.
- IDLE to RUN: on accept of MUL, or of DIV with b≠0. The iteration counter loads WIDTH.
- RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. The counter decrements each cycle. When the counter reaches 1, that edge writes the final outputs and moves to DONE.
- DONE: `out_valid`=1 for exactly this cycle. Next state is IDLE, or RUN/DONE if a new request is accepted in this cycle.

Handshake:
- `in_ready` = (state ≠ RUN).
- Accept happens on an edge where `in_valid` && `in_ready`.
- `in_valid` while RUN is ignored and not queued. The requester must hold it until `in_ready`.

Boundary rules:
- DIV by zero: `result` = all ones, `result_hi` = a, `div0`=1. Latency is 1 cycle.
- Outputs and flags hold their last completed values until the next completion. They do not update at accept or during RUN.
- `reset_n` low at any time, including mid-RUN, forces IDLE immediately. The pending op is discarded and never produces `out_valid`.

## Timing
Reset values:
- `in_ready`=1.
- `out_valid`=0.
- `result`, `result_hi`=0.
- `zero`=1.
- `neg`, `ovf`, `div0`, `bcond`=0.

Latency, counting the accept edge as cycle 0:
- Ops 0–13 and DIV by zero: `out_valid` is high in cycle 1.
- MUL and DIV: `out_valid` is high in cycle WIDTH+1 (17 at the default). `in_ready` is low in cycles 1..WIDTH.

Throughput:
- Back-to-back single-cycle ops give one result per cycle, with `out_valid` high continuously.
- Back-to-back MUL/DIV give one result per WIDTH+1 cycles.

All outputs are registered. There is no combinational path from inputs to outputs except `in_ready`, which depends on state only.

## Test plan
- ADD a=16'h7FFF, b=16'h0001: `out_valid` at cycle 1, `result`=16'h8000, `ovf`=1, `neg`=1, `zero`=0.
- MUL a=16'h1234, b=16'h5678: `in_ready` low for cycles 1–16. `out_valid` at cycle 17 with `result_hi`=16'h0626, `result`=16'h0060. Changing `a` during RUN has no effect.
- DIV a=100, b=7: `result`=14, `result_hi`=2 at cycle 17. Then DIV a=16'h1234, b=0: cycle 1 gives `result`=16'hFFFF, `result_hi`=16'h1234, `div0`=1.
- Branch ops:
  - BLZ a=16'h8000 gives `bcond`=1, `result`=0.
  - BGZ a=0 gives `bcond`=0.
  - BEQ a=b=16'h00AA gives `bcond`=1.
  - BNE with the same operands gives `bcond`=0.
- Request while RUN: issue SUB 5−3 at cycle 3 of a MUL and hold `in_valid`. SUB is accepted at cycle 17, the same cycle as the MUL `out_valid`. SUB completes at cycle 18 with `result`=2.
- Reset mid-RUN: start MUL, pull `reset_n` low at cycle 5. All outputs immediately take their reset values. After release, `in_ready`=1 and no `out_valid` ever appears for the aborted MUL.
